// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-requester round-robin arbiter for a shared synchronous-read ROM
module rom_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_re,
    input  logic [DATA_W-1:0] rom_data
);

    logic ptr;
    logic inflight;
    logic inflight_id;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic cap0;
    logic cap1;

    // A requester may only be granted once its response slot is free or being drained
    always_comb begin
        elig0 = req0_valid & ~(inflight & ~inflight_id) & (~rsp0_valid | rsp0_ready);
        elig1 = req1_valid & ~(inflight & inflight_id) & (~rsp1_valid | rsp1_ready);
        grant0 = ~rst & elig0 & (~elig1 | ~ptr);
        grant1 = ~rst & elig1 & (~elig0 | ptr);
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rom_re     = grant0 | grant1;
        rom_addr   = '0;
        if (grant0) begin
            rom_addr = req0_addr;
        end else if (grant1) begin
            rom_addr = req1_addr;
        end
    end

    assign cap0 = inflight & ~inflight_id;
    assign cap1 = inflight & inflight_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= 1'b0;
            inflight    <= 1'b0;
            inflight_id <= 1'b0;
        end else begin
            if (grant0) begin
                ptr <= 1'b1;
            end else if (grant1) begin
                ptr <= 1'b0;
            end
            inflight    <= grant0 | grant1;
            inflight_id <= grant1;
        end
    end

    // A capture at the same edge as a consume reloads the slot and keeps it valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
        end else if (cap0) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= rom_data;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else if (cap1) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= rom_data;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule
